// File: rtl/johnson_monitor_if.sv
// Signal bundle between a Johnson counter source (master) and its monitor (slave).
// Carries the sampled counter state in and the decoded phase / fault status out.
interface johnson_monitor_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int IW = $clog2(2 * N);

    logic          en;
    logic [N-1:0]  q;
    logic          clr_err;
    logic [IW-1:0] idx;
    logic          idx_vld;
    logic          wrap;
    logic [W-1:0]  rev_cnt;
    logic          err_code;
    logic          err_seq;
    logic          err_pls;

    modport master (
        output en, q, clr_err,
        input  idx, idx_vld, wrap, rev_cnt, err_code, err_seq, err_pls
    );

    modport slave (
        input  en, q, clr_err,
        output idx, idx_vld, wrap, rev_cnt, err_code, err_seq, err_pls
    );
endinterface

// File: rtl/johnson_monitor.sv
// Johnson counter monitor: decodes q to a phase index, counts revolutions and
// flags illegal codes or illegal steps against the previously sampled code.
module johnson_monitor #(
    parameter int N = 4,
    parameter int W = 8
) (
    input logic               clk,
    input logic               rst,
    johnson_monitor_if.slave  mon
);
    localparam int IW = $clog2(2 * N);

    logic [N-1:0]  q_prev;
    logic          en_prev;
    logic          primed;
    logic          fault_prev;

    logic [IW-1:0] idx_r;
    logic          idx_vld_r;
    logic          wrap_r;
    logic [W-1:0]  rev_r;
    logic          err_code_r;
    logic          err_seq_r;
    logic          err_pls_r;

    int unsigned   ntrans;
    int unsigned   pc;
    logic          legal;
    logic [IW-1:0] dec;
    logic [N-1:0]  exp_q;
    logic          code_fault;
    logic          seq_fault;
    logic          at_wrap;

    always_comb begin
        ntrans = 0;
        pc     = 0;
        for (int unsigned i = 0; i < N - 1; i++) begin
            if (mon.q[i] != mon.q[i+1]) ntrans++;
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (mon.q[i]) pc++;
        end
        legal = (ntrans <= 1);
        dec   = mon.q[N-1] ? IW'(2 * N - pc) : IW'(pc);

        exp_q      = en_prev ? {q_prev[N-2:0], ~q_prev[N-1]} : q_prev;
        code_fault = primed && !legal;
        seq_fault  = primed && legal && (mon.q != exp_q);

        // Last phase (1 followed by zeros) stepping to all-zeros closes a revolution.
        at_wrap = en_prev && q_prev[N-1] && (q_prev[N-2:0] == '0) && (mon.q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_prev     <= '0;
            en_prev    <= 1'b0;
            primed     <= 1'b0;
            fault_prev <= 1'b0;
            idx_r      <= '0;
            idx_vld_r  <= 1'b0;
            wrap_r     <= 1'b0;
            rev_r      <= '0;
            err_code_r <= 1'b0;
            err_seq_r  <= 1'b0;
            err_pls_r  <= 1'b0;
        end else begin
            q_prev     <= mon.q;
            en_prev    <= mon.en;
            primed     <= 1'b1;
            fault_prev <= code_fault | seq_fault;
            // Pulse only on the first faulty cycle of a run, so a steady fault pulses once.
            err_pls_r  <= (code_fault | seq_fault) & ~fault_prev;
            err_code_r <= (err_code_r & ~mon.clr_err) | code_fault;
            err_seq_r  <= (err_seq_r & ~mon.clr_err) | seq_fault;
            if (legal) idx_r <= dec;
            idx_vld_r  <= legal & primed;
            wrap_r     <= at_wrap;
            if (at_wrap) rev_r <= rev_r + W'(1);
        end
    end

    assign mon.idx      = idx_r;
    assign mon.idx_vld  = idx_vld_r;
    assign mon.wrap     = wrap_r;
    assign mon.rev_cnt  = rev_r;
    assign mon.err_code = err_code_r;
    assign mon.err_seq  = err_seq_r;
    assign mon.err_pls  = err_pls_r;
endmodule

// File: tb/tb_johnson_monitor.sv
// Bench for johnson_monitor: phase-table reference model, per-cycle compare on the
// falling edge, directed scenarios followed by randomized traffic with glitches.
module tb_johnson_monitor;
    localparam int N  = 4;
    localparam int W  = 2;
    localparam int IW = $clog2(2 * N);
    localparam int L  = 2 * N;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    johnson_monitor_if #(.N(N), .W(W)) mif ();

    johnson_monitor #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .mon (mif)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    // Reference model state, expressed as phase positions on the 2N-step ring.
    logic [N-1:0] m_qprev;
    bit           m_enprev, m_primed, m_faultprev;
    int           m_idx, m_rev;
    bit           m_vld, m_wrap, m_ec, m_es, m_pls;
    int           ph;

    function automatic logic [N-1:0] code_of(input int k);
        logic [N-1:0] one;
        one = 1;
        if (k <= N) return (one << k) - one;
        return ((one << (L - k)) - one) << (k - N);
    endfunction

    function automatic int phase_of(input logic [N-1:0] v);
        for (int k = 0; k < L; k++) if (code_of(k) == v) return k;
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_step(input bit r, input bit e, input bit cl, input logic [N-1:0] qv);
        int  p, pp;
        bit  cf, sf;
        if (r) begin
            m_qprev = '0; m_enprev = 0; m_primed = 0; m_faultprev = 0;
            m_idx = 0; m_rev = 0; m_vld = 0; m_wrap = 0; m_ec = 0; m_es = 0; m_pls = 0;
            return;
        end
        p  = phase_of(qv);
        pp = phase_of(m_qprev);
        cf = m_primed && (p < 0);
        // Successor of an illegal code is never legal, so any legal code after one is a step fault.
        sf = m_primed && (p >= 0) && !(pp >= 0 && p == (m_enprev ? (pp + 1) % L : pp));
        if (p >= 0) m_idx = p;
        m_vld  = (p >= 0) && m_primed;
        m_wrap = m_enprev && (pp == L - 1) && (p == 0);
        if (m_wrap) m_rev = (m_rev + 1) % (1 << W);
        m_ec   = (cl ? 1'b0 : m_ec) | cf;
        m_es   = (cl ? 1'b0 : m_es) | sf;
        m_pls  = (cf | sf) && !m_faultprev;
        m_faultprev = cf | sf;
        m_qprev  = qv;
        m_enprev = e;
        m_primed = 1;
    endtask

    // One clock: present inputs, let the edge happen, advance model and counter phase.
    task automatic step(input bit r, input bit e, input bit cl, input bit frc, input logic [N-1:0] fq);
        logic [N-1:0] qv;
        qv = frc ? fq : code_of(ph);
        rst = r; mif.en = e; mif.clr_err = cl; mif.q = qv;
        @(posedge clk);
        model_step(r, e, cl, qv);
        if (r) ph = 0;
        else if (e) ph = (ph + 1) % L;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("idx",      int'(mif.idx),      m_idx);
            chk("idx_vld",  int'(mif.idx_vld),  int'(m_vld));
            chk("wrap",     int'(mif.wrap),     int'(m_wrap));
            chk("rev_cnt",  int'(mif.rev_cnt),  m_rev);
            chk("err_code", int'(mif.err_code), int'(m_ec));
            chk("err_seq",  int'(mif.err_seq),  int'(m_es));
            chk("err_pls",  int'(mif.err_pls),  int'(m_pls));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] g;
        ph = 0;
        mif.en = 0; mif.clr_err = 0; mif.q = '0;
        @(posedge clk); #1;

        // Reset, then 24 enabled steps; the third wrap is seen one edge later.
        step(1, 0, 0, 0, '0);
        chk_on = 1'b1;
        chk("rst_idx_vld", int'(mif.idx_vld), 0);
        chk("rst_rev",     int'(mif.rev_cnt), 0);
        for (int i = 0; i < 24; i++) step(0, 1, 0, 0, '0);
        step(0, 0, 0, 0, '0);
        chk("t1_rev",  int'(mif.rev_cnt), 3);
        chk("t1_wrap", int'(mif.wrap), 1);
        chk("t1_errs", int'({mif.err_code, mif.err_seq}), 0);

        // Enable pattern 1,0,0 repeating: idx must hold on idle cycles.
        for (int i = 0; i < 20; i++) step(0, (i % 3) == 0, 0, 0, '0);
        chk("t2_errs", int'({mif.err_code, mif.err_seq}), 0);

        // Single-cycle illegal code glitch.
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0);
        step(0, 0, 0, 1, 4'b0101);
        chk("t3_code", int'(mif.err_code), 1);
        chk("t3_pls",  int'(mif.err_pls), 1);
        chk("t3_vld",  int'(mif.idx_vld), 0);
        step(0, 0, 0, 0, '0);
        chk("t3_vld_back", int'(mif.idx_vld), 1);
        chk("t3_pls_once", int'(mif.err_pls), 0);
        chk("t3_sticky",   int'(mif.err_code), 1);

        // Clear with no fault, then clear colliding with a new fault.
        step(0, 0, 1, 0, '0);
        chk("t5_clr", int'({mif.err_code, mif.err_seq}), 0);
        step(0, 0, 1, 1, 4'b1011);
        chk("t5_clr_vs_fault", int'(mif.err_code), 1);

        // Skip 0011 -> 1111 with en=1.
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0);
        ph = 4;
        step(0, 1, 0, 0, '0);
        chk("t4_seq", int'(mif.err_seq), 1);
        chk("t4_pls", int'(mif.err_pls), 1);
        chk("t4_idx", int'(mif.idx), 4);
        chk("t4_code", int'(mif.err_code), 0);

        // Five revolutions on a 2-bit counter, then reset mid-revolution.
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 5 * L + 1; i++) step(0, 1, 0, 0, '0);
        chk("t6_rev", int'(mif.rev_cnt), 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0);
        step(1, 1, 0, 0, '0);
        chk("t6_rst_idx", int'(mif.idx), 0);
        chk("t6_rst_errs", int'({mif.err_code, mif.err_seq, mif.err_pls}), 0);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, '0);

        // Randomized traffic with glitches, skips, clears and resets.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 29) == 0) ph = $urandom_range(0, L - 1);
            g = N'($urandom);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0, g);
        end

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
